// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// cpu_pkg : shared CPU front-end types and constants
// Rev 1.0 : initial release
// ============================================================================
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } if_state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// if_stage : instruction fetch, PC ownership and im read-latency re-alignment
// Rev 1.0 : initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_dout,
    output logic [31:0]       if_instr,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc4,
    output logic              if_valid
);

    localparam logic [31:0] C_RESET_PC_ALIGNED = RESET_PC & ~32'h3;

    logic [31:0] pc_q;
    logic [31:0] pc_d1;
    logic [31:0] held_instr;
    logic        valid_d1;
    if_state_t   state;

    // Masking keeps all redirect_pc bits referenced while forcing word alignment.
    logic [31:0] w_redirect_target;
    assign w_redirect_target = redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= C_RESET_PC_ALIGNED;
            pc_d1      <= C_RESET_PC_ALIGNED;
            held_instr <= NOP_INSTR;
            valid_d1   <= 1'b0;
            state      <= PRIME;
        end else if (redirect) begin
            pc_q     <= w_redirect_target;
            valid_d1 <= 1'b0;
            state    <= RUN;
        end else begin
            case (state)
                PRIME: begin
                    pc_d1    <= pc_q;
                    pc_q     <= pc_q + 32'd4;
                    valid_d1 <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        held_instr <= imem_dout;
                        state      <= HOLD;
                    end else begin
                        pc_d1    <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        valid_d1 <= 1'b1;
                    end
                end
                HOLD: begin
                    // im keeps reading pc_q, so releasing picks up the next word directly.
                    if (!stall) begin
                        pc_d1    <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        valid_d1 <= 1'b1;
                        state    <= RUN;
                    end
                end
                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

    always_comb begin
        if_instr = NOP_INSTR;
        case (state)
            RUN:     if_instr = imem_dout;
            HOLD:    if_instr = held_instr;
            default: if_instr = NOP_INSTR;
        endcase
    end

    assign imem_addr = pc_q[ADDR_W+1:2];
    assign if_pc     = pc_d1;
    assign if_pc4    = pc_d1 + 32'd4;
    assign if_valid  = valid_d1 && (state != PRIME);

endmodule : if_stage
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage that sits directly upstream of the synchronous-read instruction memory `im`. It owns the program counter and drives `im`'s word address. It re-aligns `im`'s one-cycle read latency so each returned instruction pairs with its PC. It presents an (instruction, PC, PC+4, valid) bundle to decode, with stall hold and single-bubble redirect for branches and jumps.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: byte address fetched first after reset.
- `ADDR_W`, 8: width of the `im` word address.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `stall`, in, 1: decode cannot accept; hold the current output bundle.
- `redirect`, in, 1: load a new PC; wrong-path fetch is discarded.
- `redirect_pc`, in, 32: redirect target byte address; bits [1:0] ignored.
- `imem_addr`, out, ADDR_W: word address to `im` = `pc_q[ADDR_W+1:2]`.
- `imem_dout`, in, 32: `im` read data, valid the cycle after the address is presented.
- `if_instr`, out, 32: instruction for decode.
- `if_pc`, out, 32: byte address of `if_instr`.
- `if_pc4`, out, 32: `if_pc + 4`, modulo 2^32.
- `if_valid`, out, 1: bundle is a real instruction.

## Operation
- Registers:
  - `pc_q` is the address being read.
  - `pc_d1` is the PC of the word currently on `imem_dout`; it drives `if_pc`.
  - `held_instr` holds the instruction during a stall.
  - `valid_d1` tracks whether the word on `imem_dout` is real.
  - `state` is one of PRIME, RUN, HOLD.
- `pc_q[1:0]` is always 2'b00. The PC increments by 4 with natural 32-bit wrap. `imem_addr` truncates, so PCs beyond the memory alias.
- `if_instr` comes from three sources:
  - PRIME: 32'h0.
  - HOLD: `held_instr`.
  - RUN: `imem_dout`.
- PRIME is entered on reset; `if_valid` = 0. At the next edge: `pc_d1` ← `pc_q`, `pc_q` += 4, `valid_d1` ← 1, next state RUN.
- RUN with no stall and no redirect: `pc_d1` ← `pc_q`, `pc_q` += 4, `valid_d1` ← 1.
- RUN with `stall`: `held_instr` ← `imem_dout` and the state moves to HOLD. `pc_q`, `pc_d1` and `valid_d1` do not change.
- HOLD with `stall`: everything holds. `im` keeps reading `pc_q`, which is the next instruction.
- HOLD without `stall`: advance exactly as in RUN, then go to RUN. The next cycle's `imem_dout` = `im[pc_q]`, so no instruction is lost.
- `redirect` has the highest priority, above `stall`, in every state including PRIME:
  - `pc_q` ← {`redirect_pc[31:2]`, 2'b00}.
  - `valid_d1` ← 0.
  - Next state RUN.
  - The bundle presented during the redirect cycle is not squashed by this block; downstream owns that decision.
- `if_valid` = `valid_d1` in RUN/HOLD and 0 in PRIME. During HOLD it reflects the validity of the held bundle.

## Timing
- Reset values:
  - `pc_q` = `RESET_PC`.
  - `imem_addr` = `RESET_PC[ADDR_W+1:2]`.
  - `pc_d1` = `RESET_PC`.
  - `held_instr` = 0.
  - `valid_d1` = 0, state PRIME.
  - Outputs therefore reset to: `if_instr` 0, `if_pc` `RESET_PC`, `if_pc4` `RESET_PC`+4, `if_valid` 0.
- Reset asserted mid-operation takes effect immediately, without waiting for a clock edge. The first valid bundle appears one cycle after the first edge following reset release.
- Latency from address issue to bundle: 1 cycle. Throughput: 1 instruction per cycle when not stalled.
- Redirect penalty is exactly 1 bubble: `if_valid` = 0 in the cycle after the redirect edge, and the target bundle appears in the following cycle.
- A stall asserted in cycle n freezes the outputs from cycle n+1 (the cycle-n bundle persists) until the cycle after `stall` drops. `imem_addr` is constant throughout the stall.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` default.
  - `if_state_t` enum (PRIME, RUN, HOLD).
  - `NOP_INSTR` = 32'h0.
- Single flat module; no sub-module warranted.

## Test plan
`im` is preloaded with 341d000c, 34021234, 34033456, 00432021, …, with `im[12]` = 1065fffd and `im[13]` = 0c000c0e.
- Reset release, free run: `if_valid` 0 for one cycle, then (`if_pc`, `if_instr`) = (0x0, 341d000c), (0x4, 34021234), (0x8, 34033456); `if_pc4` is always `if_pc` + 4.
- Stall 3 cycles while `if_pc` = 0x8: `if_instr` holds 34033456 with `if_valid` 1 and `imem_addr` stays 0x03. After release the next bundle is (0xC, 00432021) with no gap and no duplicate.
- Redirect to 0x34 while `if_pc` = 0x10: next cycle `if_valid` 0, then (0x34, 0c000c0e), then (0x38, …).
- `stall` and `redirect` (target 0x30) asserted together in HOLD: the redirect wins, one bubble follows, then (0x30, 1065fffd).
- Asynchronous `rst` pulse between edges mid-run: `if_valid` and `imem_addr` go to 0 immediately with no clock edge; the sequence restarts at (0x0, 341d000c).
- Misaligned redirect to 0x37: behaves exactly as a redirect to 0x34.
